// File: rtl/vga_dma_sequencer_pkg.sv
// Shared definitions for the VGA line DMA sequencer: DMA control register
// offsets, sequencer state encodings and the FIFO room test.
package vga_dma_sequencer_pkg;

    localparam logic [2:0] S_ADDR      = 3'd0;
    localparam logic [2:0] LONGTH      = 3'd1;
    localparam logic [2:0] CONTROL     = 3'd2;
    localparam logic [2:0] START_ADDR  = 3'd3;
    localparam logic [2:0] STATUS_ADDR = 3'd4;

    typedef enum logic [3:0] {
        SEQ_IDLE      = 4'd0,
        SEQ_WR_CTRL   = 4'd1,
        SEQ_WAIT_ROOM = 4'd2,
        SEQ_WR_SADDR  = 4'd3,
        SEQ_WR_LEN    = 4'd4,
        SEQ_WR_START  = 4'd5,
        SEQ_WAIT_IRQ  = 4'd6,
        SEQ_WR_CLR    = 4'd7,
        SEQ_NEXT      = 4'd8
    } seq_state_e;

    // True when a whole line fits in the pixel FIFO on top of its current fill.
    function automatic logic fifo_has_room(input logic [11:0] used, input logic [31:0] limit);
        return ({20'd0, used} <= limit);
    endfunction

endpackage

// File: rtl/vga_dma_sequencer_avm_single_writer.sv
// One-outstanding-write Avalon-MM master: captures addr/data on issue, holds
// them through waitrequest, and pulses done in the idle cycle after completion.
module avm_single_writer
    import vga_dma_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        issue,
    input  logic [2:0]  addr,
    input  logic [31:0] data,
    input  logic        waitrequest,
    output logic [2:0]  avm_address,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic        done
);

    logic        write_r;
    logic        done_r;
    logic [2:0]  address_r;
    logic [31:0] writedata_r;

    // Write handshake; the done cycle doubles as the mandatory idle gap.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            write_r     <= 1'b0;
            done_r      <= 1'b0;
            address_r   <= 3'd0;
            writedata_r <= 32'd0;
        end else if (write_r) begin
            if (!waitrequest) begin
                write_r <= 1'b0;
                done_r  <= 1'b1;
            end else begin
                done_r  <= 1'b0;
            end
        end else if (issue && !done_r) begin
            write_r     <= 1'b1;
            done_r      <= 1'b0;
            address_r   <= addr;
            writedata_r <= data;
        end else begin
            done_r <= 1'b0;
        end
    end

    assign avm_address   = address_r;
    assign avm_write     = write_r;
    assign avm_writedata = writedata_r;
    assign done          = done_r;

endmodule

// File: rtl/vga_dma_sequencer.sv
// Frame scheduler for the 1-bit VGA line DMA: programs, starts and acknowledges
// the DMA once per line, throttled on pixel FIFO fill level.
module vga_dma_sequencer
    import vga_dma_sequencer_pkg::*;
#(
    parameter int LINES       = 480,
    parameter int LINE_BYTES  = 80,
    parameter int LINE_STRIDE = 80,
    parameter int FIFO_DEPTH  = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cfg_enable,
    input  logic [31:0] cfg_fb_base,
    input  logic        frame_start,
    output logic [2:0]  avm_ctl_address,
    output logic        avm_ctl_write,
    output logic [31:0] avm_ctl_writedata,
    input  logic        avm_ctl_waitrequest,
    input  logic        dma_irq,
    input  logic [11:0] fifo_wruserdw,
    output logic        busy,
    output logic [15:0] cur_line,
    output logic        frame_done,
    output logic        overrun
);

    localparam logic [31:0] LEN_WORD_C   = 32'(LINE_BYTES - 2);
    localparam logic [31:0] ROOM_LIMIT_C = 32'(FIFO_DEPTH - LINE_BYTES / 2);
    localparam logic [31:0] STRIDE_C     = 32'(LINE_STRIDE);
    localparam logic [15:0] LINES_C      = 16'(LINES);

    seq_state_e  state_r;
    seq_state_e  next_state_s;
    logic        issue_s;
    logic [2:0]  wr_addr_s;
    logic [31:0] wr_data_s;
    logic        wr_done_s;
    logic        start_s;
    logic        room_s;
    logic [31:0] base_r;
    logic [31:0] offset_r;
    logic [15:0] line_r;
    logic        busy_r;
    logic        frame_done_r;
    logic        overrun_r;
    logic        irq_arm_r;

    assign start_s = frame_start && cfg_enable && (state_r == SEQ_IDLE);
    assign room_s  = fifo_has_room(fifo_wruserdw, ROOM_LIMIT_C);

    avm_single_writer u_writer (
        .clk           (clk),
        .reset_n       (reset_n),
        .issue         (issue_s),
        .addr          (wr_addr_s),
        .data          (wr_data_s),
        .waitrequest   (avm_ctl_waitrequest),
        .avm_address   (avm_ctl_address),
        .avm_write     (avm_ctl_write),
        .avm_writedata (avm_ctl_writedata),
        .done          (wr_done_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= SEQ_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and write-request decode; each WR_* state owns exactly one write.
    always_comb begin
        next_state_s = state_r;
        issue_s      = 1'b0;
        wr_addr_s    = CONTROL;
        wr_data_s    = 32'd0;
        case (state_r)
            SEQ_IDLE: begin
                if (start_s) next_state_s = SEQ_WR_CTRL;
                else         next_state_s = SEQ_IDLE;
            end
            SEQ_WR_CTRL: begin
                issue_s   = 1'b1;
                wr_addr_s = CONTROL;
                if (wr_done_s) next_state_s = SEQ_WAIT_ROOM;
                else           next_state_s = SEQ_WR_CTRL;
            end
            SEQ_WAIT_ROOM: begin
                if (room_s) next_state_s = SEQ_WR_SADDR;
                else        next_state_s = SEQ_WAIT_ROOM;
            end
            SEQ_WR_SADDR: begin
                issue_s   = 1'b1;
                wr_addr_s = S_ADDR;
                wr_data_s = base_r + offset_r;
                if (wr_done_s) next_state_s = SEQ_WR_LEN;
                else           next_state_s = SEQ_WR_SADDR;
            end
            SEQ_WR_LEN: begin
                issue_s   = 1'b1;
                wr_addr_s = LONGTH;
                wr_data_s = LEN_WORD_C;
                if (wr_done_s) next_state_s = SEQ_WR_START;
                else           next_state_s = SEQ_WR_LEN;
            end
            SEQ_WR_START: begin
                issue_s   = 1'b1;
                wr_addr_s = START_ADDR;
                if (wr_done_s) next_state_s = SEQ_WAIT_IRQ;
                else           next_state_s = SEQ_WR_START;
            end
            SEQ_WAIT_IRQ: begin
                if (irq_arm_r && dma_irq) next_state_s = SEQ_WR_CLR;
                else                      next_state_s = SEQ_WAIT_IRQ;
            end
            SEQ_WR_CLR: begin
                issue_s   = 1'b1;
                wr_addr_s = STATUS_ADDR;
                if (wr_done_s) next_state_s = SEQ_NEXT;
                else           next_state_s = SEQ_WR_CLR;
            end
            SEQ_NEXT: begin
                if (line_r == LINES_C)  next_state_s = SEQ_IDLE;
                else if (!cfg_enable)   next_state_s = SEQ_IDLE;
                else                    next_state_s = SEQ_WAIT_ROOM;
            end
            default: begin
                next_state_s = SEQ_IDLE;
            end
        endcase
    end

    // Frame datapath: base/offset/line tracking, busy, done pulse and sticky overrun.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            base_r       <= 32'd0;
            offset_r     <= 32'd0;
            line_r       <= 16'd0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            overrun_r    <= 1'b0;
            irq_arm_r    <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            // The first WAIT_IRQ cycle is blind to cover the DMA start latency.
            irq_arm_r    <= (state_r == SEQ_WAIT_IRQ);
            if (frame_start && (state_r != SEQ_IDLE)) begin
                overrun_r <= 1'b1;
            end
            case (state_r)
                SEQ_IDLE: begin
                    if (start_s) begin
                        base_r   <= cfg_fb_base;
                        offset_r <= 32'd0;
                        line_r   <= 16'd0;
                        busy_r   <= 1'b1;
                    end
                end
                SEQ_WR_CLR: begin
                    if (wr_done_s) begin
                        line_r   <= line_r + 16'd1;
                        offset_r <= offset_r + STRIDE_C;
                    end
                end
                SEQ_NEXT: begin
                    if (line_r == LINES_C) begin
                        frame_done_r <= 1'b1;
                        busy_r       <= 1'b0;
                    end else if (!cfg_enable) begin
                        busy_r <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy       = busy_r;
    assign cur_line   = line_r;
    assign frame_done = frame_done_r;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_vga_dma_sequencer.sv
// Scoreboard bench for vga_dma_sequencer (LINES=3, LINE_STRIDE=100): a DMA
// responder/monitor pops expected writes as the DUT completes them.
module tb_vga_dma_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cfg_enable;
    logic [31:0] cfg_fb_base;
    logic        frame_start;
    logic [2:0]  avm_ctl_address;
    logic        avm_ctl_write;
    logic [31:0] avm_ctl_writedata;
    logic        avm_ctl_waitrequest;
    logic        dma_irq;
    logic [11:0] fifo_wruserdw;
    logic        busy;
    logic [15:0] cur_line;
    logic        frame_done;
    logic        overrun;

    always #5 clk = ~clk;

    vga_dma_sequencer #(
        .LINES(3), .LINE_BYTES(80), .LINE_STRIDE(100), .FIFO_DEPTH(4096)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cfg_enable(cfg_enable), .cfg_fb_base(cfg_fb_base),
        .frame_start(frame_start), .avm_ctl_address(avm_ctl_address),
        .avm_ctl_write(avm_ctl_write), .avm_ctl_writedata(avm_ctl_writedata),
        .avm_ctl_waitrequest(avm_ctl_waitrequest), .dma_irq(dma_irq),
        .fifo_wruserdw(fifo_wruserdw), .busy(busy), .cur_line(cur_line),
        .frame_done(frame_done), .overrun(overrun)
    );

    localparam logic [2:0] A_SADDR = 3'd0;
    localparam logic [2:0] A_LEN   = 3'd1;
    localparam logic [2:0] A_CTRL  = 3'd2;
    localparam logic [2:0] A_START = 3'd3;
    localparam logic [2:0] A_STAT  = 3'd4;

    typedef struct packed {
        logic [2:0]  addr;
        logic [31:0] data;
        logic [15:0] line;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  passes = 0;
    int  writes_seen = 0;
    int  saddr_seen = 0;
    int  start_seen = 0;
    int  done_seen = 0;
    int  irq_cnt = 0;
    int  irq_delay = 10;
    int  stall_arm = 0;
    int  len_hi = 0;
    logic        prev_stall = 1'b0;
    logic [2:0]  prev_addr = 3'd0;
    logic [31:0] prev_data = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // DMA responder and scoreboard monitor, sampling away from the active edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            dma_irq = 1'b0;
            irq_cnt = 0;
            prev_stall = 1'b0;
            avm_ctl_waitrequest = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_write_held", {31'd0, avm_ctl_write}, 32'd1);
                check("stall_addr_held", {29'd0, avm_ctl_address}, {29'd0, prev_addr});
                check("stall_data_held", avm_ctl_writedata, prev_data);
            end
            if (avm_ctl_write && avm_ctl_address == A_LEN) len_hi++;
            if (avm_ctl_write && avm_ctl_address == A_LEN && stall_arm > 0) begin
                avm_ctl_waitrequest = 1'b1;
                stall_arm--;
            end else begin
                avm_ctl_waitrequest = 1'b0;
            end
            prev_stall = avm_ctl_write && avm_ctl_waitrequest;
            prev_addr  = avm_ctl_address;
            prev_data  = avm_ctl_writedata;
            if (avm_ctl_write && !avm_ctl_waitrequest) begin
                writes_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_write: addr %0d data 0x%0h, expected none",
                             avm_ctl_address, avm_ctl_writedata);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", {29'd0, avm_ctl_address}, {29'd0, e.addr});
                    check("wr_data", avm_ctl_writedata, e.data);
                    check("cur_line", {16'd0, cur_line}, {16'd0, e.line});
                end
                if (avm_ctl_address == A_SADDR) saddr_seen++;
                if (avm_ctl_address == A_START) begin
                    start_seen++;
                    irq_cnt = irq_delay;
                end
                if (avm_ctl_address == A_STAT) dma_irq = 1'b0;
            end else if (irq_cnt > 0) begin
                irq_cnt--;
                if (irq_cnt == 0) dma_irq = 1'b1;
            end
            if (frame_done) done_seen++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] a2, input int nlines);
        logic [31:0] addrs [3];
        addrs[0] = a0; addrs[1] = a1; addrs[2] = a2;
        exp_q.push_back('{A_CTRL, 32'd0, 16'd0});
        for (int l = 0; l < nlines; l++) begin
            exp_q.push_back('{A_SADDR, addrs[l], 16'(l)});
            exp_q.push_back('{A_LEN,   32'd78,   16'(l)});
            exp_q.push_back('{A_START, 32'd0,    16'(l)});
            exp_q.push_back('{A_STAT,  32'd0,    16'(l)});
        end
    endtask

    task automatic pulse_start(input logic [31:0] base);
        cfg_fb_base = base;
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!busy && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        check(name, {31'd0, ok}, 32'd1);
        tick(2);
    endtask

    task automatic clear_counts();
        writes_seen = 0; saddr_seen = 0; start_seen = 0; done_seen = 0; len_hi = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        logic found;
        reset_n = 1'b0; cfg_enable = 1'b1; cfg_fb_base = 32'd0; frame_start = 1'b0;
        avm_ctl_waitrequest = 1'b0; dma_irq = 1'b0; fifo_wruserdw = 12'd0;
        tick(3);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_write", {31'd0, avm_ctl_write}, 32'd0);
        check("rst_addr", {29'd0, avm_ctl_address}, 32'd0);
        check("rst_data", avm_ctl_writedata, 32'd0);
        check("rst_cur_line", {16'd0, cur_line}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        reset_n = 1'b1;
        tick(2);

        // Basic 3-line frame.
        clear_counts();
        push_frame(32'h0010_0000, 32'h0010_0064, 32'h0010_00C8, 3);
        pulse_start(32'h0010_0000);
        tick(1);
        check("busy_after_start", {31'd0, busy}, 32'd1);
        wait_done("basic_complete");
        check("basic_frame_done", done_seen, 32'd1);
        check("basic_writes", writes_seen, 32'd13);
        check("basic_busy_low", {31'd0, busy}, 32'd0);

        // Waitrequest stall on first LONGTH, with 32-bit address wrap.
        clear_counts();
        stall_arm = 5;
        push_frame(32'hFFFF_FFA0, 32'h0000_0004, 32'h0000_0068, 3);
        pulse_start(32'hFFFF_FFA0);
        wait_done("stall_complete");
        check("stall_len_high_cycles", len_hi, 32'd8);
        check("stall_writes", writes_seen, 32'd13);
        check("stall_frame_done", done_seen, 32'd1);

        // FIFO throttle at the room boundary.
        clear_counts();
        fifo_wruserdw = 12'd4060;
        push_frame(32'h0010_0000, 32'h0010_0064, 32'h0010_00C8, 3);
        pulse_start(32'h0010_0000);
        tick(30);
        check("throttle_no_saddr", saddr_seen, 32'd0);
        check("throttle_ctrl_only", writes_seen, 32'd1);
        fifo_wruserdw = 12'd4056;
        found = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick(1);
            if (avm_ctl_write && avm_ctl_address == A_SADDR) found = 1'b1;
        end
        check("throttle_saddr_within_2", {31'd0, found}, 32'd1);
        wait_done("throttle_complete");
        fifo_wruserdw = 12'd0;
        check("throttle_frame_done", done_seen, 32'd1);

        // Overrun: frame_start during WAIT_IRQ is ignored but flagged.
        clear_counts();
        irq_delay = 30;
        push_frame(32'h0010_0000, 32'h0010_0064, 32'h0010_00C8, 3);
        pulse_start(32'h0010_0000);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (start_seen > 0) begin
                found = 1'b1;
                break;
            end
            tick(1);
        end
        check("overrun_reached_irq_wait", {31'd0, found}, 32'd1);
        tick(5);
        pulse_start(32'h0020_0000);
        tick(1);
        check("overrun_set", {31'd0, overrun}, 32'd1);
        wait_done("overrun_complete");
        irq_delay = 10;
        check("overrun_frame_done", done_seen, 32'd1);
        check("overrun_writes", writes_seen, 32'd13);

        // frame_start with cfg_enable low is ignored.
        clear_counts();
        cfg_enable = 1'b0;
        pulse_start(32'h0010_0000);
        tick(3);
        check("disabled_start_busy", {31'd0, busy}, 32'd0);
        check("disabled_start_writes", writes_seen, 32'd0);

        // cfg_enable drop during line 1 truncates after that line.
        cfg_enable = 1'b1;
        push_frame(32'h0010_0000, 32'h0010_0064, 32'h0010_00C8, 2);
        pulse_start(32'h0010_0000);
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (start_seen > 1) begin
                found = 1'b1;
                break;
            end
            tick(1);
        end
        check("trunc_reached_line1", {31'd0, found}, 32'd1);
        cfg_enable = 1'b0;
        wait_done("trunc_complete");
        tick(10);
        check("trunc_no_frame_done", done_seen, 32'd0);
        check("trunc_writes", writes_seen, 32'd9);
        check("trunc_busy_low", {31'd0, busy}, 32'd0);
        cfg_enable = 1'b1;

        // Reset while the LONGTH write is stalled.
        clear_counts();
        check("pre_reset_overrun", {31'd0, overrun}, 32'd1);
        stall_arm = 50;
        push_frame(32'h0010_0000, 32'h0010_0064, 32'h0010_00C8, 3);
        pulse_start(32'h0010_0000);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (avm_ctl_write && avm_ctl_address == A_LEN) begin
                found = 1'b1;
                break;
            end
            tick(1);
        end
        check("reset_reached_len", {31'd0, found}, 32'd1);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        stall_arm = 0;
        exp_q.delete();
        check("reset_write_low", {31'd0, avm_ctl_write}, 32'd0);
        check("reset_busy_low", {31'd0, busy}, 32'd0);
        check("reset_overrun_clear", {31'd0, overrun}, 32'd0);
        clear_counts();
        tick(5);
        check("reset_no_more_writes", writes_seen, 32'd0);
        push_frame(32'h0030_0000, 32'h0030_0064, 32'h0030_00C8, 3);
        pulse_start(32'h0030_0000);
        wait_done("restart_complete");
        check("restart_frame_done", done_seen, 32'd1);
        check("restart_writes", writes_seen, 32'd13);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
